// File: rtl/uart_prog_pkg.sv
// Shared types and defaults for the UART boot-programming loader.
package uart_prog_pkg;
    localparam int unsigned CLKS_PER_BIT_DEF = 347;
    localparam logic [31:0] END_WORD_DEF     = 32'h0000_0FFF;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_EMIT
    } rx_state_e;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, baud counter and framing FSM.
module uart_rx_byte
    import uart_prog_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta, rxs;
    rx_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    assign data = shreg;
    assign busy = (state != RX_IDLE);

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            cnt       <= cnt + CNT_W'(1);
            if (!en) begin
                state   <= RX_IDLE;
                cnt     <= '0;
                bit_idx <= '0;
            end else begin
                case (state)
                    RX_IDLE: begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (!rxs) state <= RX_START;
                    end
                    RX_START: if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        state <= rxs ? RX_IDLE : RX_DATA;
                    end
                    RX_DATA: if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end
                    RX_STOP: if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= RX_EMIT;
                            valid <= 1'b1;
                        end else begin
                            state     <= RX_IDLE;
                            frame_err <= 1'b1;
                        end
                    end
                    RX_EMIT: state <= RX_IDLE;
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: packs received bytes into little-endian words and streams
// them into instruction memory until the end-of-program word arrives.
module uart_prog_loader
    import uart_prog_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned ADDR_W       = 13,
    parameter logic [31:0] END_WORD     = END_WORD_DEF
)(
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              rx_i,
    input  logic              en_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              frame_err_o,
    output logic              ovf_o
);
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ferr, rx_busy;
    logic [1:0]  byte_cnt;
    logic [23:0] partial;
    logic [31:0] word, full_word;
    logic        wr_pend, end_pend;

    assign full_word = {rx_data, partial};
    assign busy_o    = rx_busy | (byte_cnt != 2'd0);

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .en        (en_i & ~done_o),
        .rx        (rx_i),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_ferr),
        .busy      (rx_busy)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            we_o        <= 1'b0;
            addr_o      <= '0;
            wdata_o     <= '0;
            done_o      <= 1'b0;
            frame_err_o <= 1'b0;
            ovf_o       <= 1'b0;
            byte_cnt    <= '0;
            partial     <= '0;
            word        <= '0;
            wr_pend     <= 1'b0;
            end_pend    <= 1'b0;
        end else begin
            we_o     <= 1'b0;
            wr_pend  <= 1'b0;
            end_pend <= 1'b0;
            if (rx_ferr)  frame_err_o <= 1'b1;
            if (end_pend) done_o      <= 1'b1;
            if (wr_pend) begin
                we_o    <= 1'b1;
                wdata_o <= word;
            end
            // Address advances after the strobe so addr_o matches the write.
            if (we_o) begin
                addr_o <= addr_o + ADDR_W'(1);
                if (&addr_o) ovf_o <= 1'b1;
            end
            if (!en_i) begin
                byte_cnt <= '0;
                partial  <= '0;
            end else if (rx_valid) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: partial[7:0]   <= rx_data;
                    2'd1: partial[15:8]  <= rx_data;
                    2'd2: partial[23:16] <= rx_data;
                    default: begin
                        partial <= '0;
                        word    <= full_word;
                        if (full_word == END_WORD) end_pend <= 1'b1;
                        else                       wr_pend  <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader at 8 clocks per bit, 4-bit addresses.
module tb_uart_prog_loader;
    localparam int CLKS = 8;
    localparam int AW   = 4;
    // sync(2) + start detect(1) + half bit + 8 data + stop, then 2 to the strobe
    localparam int LAT  = 3 + CLKS / 2 + 9 * CLKS + 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          rx_i     = 1'b1;
    logic          en_i     = 1'b0;
    logic          we_o, busy_o, done_o, frame_err_o, ovf_o;
    logic [AW-1:0] addr_o;
    logic [31:0]   wdata_o;

    wr_t    exp_q[$];
    int     n_chk  = 0;
    int     n_fail = 0;
    longint cyc     = 0;
    longint exp_cyc = 0;

    uart_prog_loader #(.CLKS_PER_BIT(CLKS), .ADDR_W(AW), .END_WORD(32'h0000_0FFF)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .rx_i        (rx_i),
        .en_i        (en_i),
        .we_o        (we_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .frame_err_o (frame_err_o),
        .ovf_o       (ovf_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge wb_clk_i) begin
        if (we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", exp_q.size(), 1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", addr_o, e.addr);
                chk("wr_data", wdata_o, e.data);
                chk("wr_lat", cyc, exp_cyc);
            end
        end
    end

    function automatic void push(input logic [AW-1:0] a, input logic [31:0] d);
        exp_q.push_back(wr_t'{addr: a, data: d});
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx_i = v;
        tick(CLKS);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        exp_cyc = cyc + LAT;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx_i = 1'b1;
        tick(2);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        rx_i     = 1'b1;
        tick(3);
        wb_rst_i = 1'b0;
        tick(2);
    endtask

    task automatic check_reset(input string t);
        chk({t, "_we"},   we_o, 0);
        chk({t, "_addr"}, addr_o, 0);
        chk({t, "_data"}, wdata_o, 0);
        chk({t, "_busy"}, busy_o, 0);
        chk({t, "_done"}, done_o, 0);
        chk({t, "_ferr"}, frame_err_o, 0);
        chk({t, "_ovf"},  ovf_o, 0);
    endtask

    initial begin
        en_i = 1'b1;
        do_reset();
        check_reset("rst0");

        // One real word, then the end marker: single write, done, receiver frozen.
        push(0, 32'h0000_0513);
        send_word(32'h0000_0513);
        send_word(32'h0000_0FFF);
        tick(4);
        chk("t1_done", done_o, 1);
        chk("t1_busy", busy_o, 0);
        rx_i = 1'b0;
        tick(12);
        chk("t1_frozen_busy", busy_o, 0);
        rx_i = 1'b1;
        tick(10 * CLKS);

        // Address wrap: 17 words into a 16-word space.
        do_reset();
        check_reset("rst1");
        for (int i = 0; i < 17; i++) begin
            push(AW'(i), 32'(i));
            send_word(32'(i));
            tick(2);
            if (i == 14) chk("t2_ovf_pre", ovf_o, 0);
            if (i == 15) chk("t2_ovf_wrap", ovf_o, 1);
        end
        chk("t2_addr_end", addr_o, 1);
        chk("t2_ovf_end", ovf_o, 1);

        // Short glitch while idle is rejected silently.
        do_reset();
        rx_i = 1'b0;
        tick(2);
        rx_i = 1'b1;
        tick(20);
        chk("t3_busy", busy_o, 0);
        chk("t3_ferr", frame_err_o, 0);
        push(0, 32'h0403_0201);
        send_word(32'h0403_0201);

        // Bad stop bit: byte dropped, partial word kept.
        push(1, 32'h0403_0201);
        send_byte(8'h01);
        send_byte(8'hAA, 1'b0);
        tick(CLKS);
        chk("t4_ferr", frame_err_o, 1);
        chk("t4_partial_busy", busy_o, 1);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        tick(2);
        chk("t4_ferr_sticky", frame_err_o, 1);

        // Enable drop discards a partial word.
        do_reset();
        push(0, 32'h4433_2211);
        send_byte(8'h55);
        send_byte(8'h66);
        en_i = 1'b0;
        tick(3);
        chk("t5_busy_off", busy_o, 0);
        en_i = 1'b1;
        tick(2);
        send_word(32'h4433_2211);
        tick(2);
        chk("t5_addr", addr_o, 1);

        // Reset in the middle of the third byte's data bits.
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        wb_rst_i = 1'b1;
        rx_i     = 1'b1;
        tick(2);
        wb_rst_i = 1'b0;
        tick(2);
        check_reset("t6_rst");
        push(0, 32'hEFBE_ADDE);
        send_word(32'hEFBE_ADDE);
        tick(4);

        chk("q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
